// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin stream arbiters.
//   ARB_N_REQ_MAX : largest requester count the arbiters are built for
//   out_state_t   : occupancy of a single-beat registered output stage
//   rr_next()     : wrap-around increment of a round-robin index
package arb_pkg;

    localparam int ARB_N_REQ_MAX = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Index after idx in a ring of n entries (n-1 wraps to 0).
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Picks the first set bit of req, searching from index ptr upward and
// wrapping past N-1 back to 0.
//   req    : request vector
//   ptr    : index holding highest priority
//   winner : selected index (0 when nothing is requested)
//   found  : at least one request is set
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           found
);

    // Each index gets a rotated distance from ptr; the smallest distance
    // among active requests wins. This keeps every bit select static.
    always_comb begin
        int off;
        int best;
        winner = '0;
        found  = 1'b0;
        best   = N;
        off    = 0;
        for (int k = 0; k < N; k++) begin
            off = k - int'(ptr);
            if (off < 0) off = off + N;
            if (req[k] && (off < best)) begin
                best   = off;
                winner = IDW'(k);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave channel among N_REQ
// masters, with a single-beat registered output stage.
//
// Optional build macro RR_STREAM_ARBITER_PKT_LOCK_EN: adds i_req_last and
// o_last and keeps the grant on one requester until its last beat.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req_valid  : per-requester valid
//   i_req_data   : requester k at bits [k*DATA_W +: DATA_W]
//   o_req_ready  : per-requester ready, one-hot or zero
//   o_valid      : output beat valid (registered)
//   o_data       : output beat (registered)
//   o_grant_id   : requester that sourced o_data (registered)
//   i_ready      : slave ready
//   i_req_last   : (macro) per-requester last-beat flag
//   o_last       : (macro) last flag registered with o_data
//
// Handshake: a beat moves on any edge where valid and ready are both high;
// a master keeps valid and data steady until that edge, and ready may
// depend combinationally on valid (and on i_ready through the load term).
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 32,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    input  logic [N_REQ-1:0]        i_req_last,
    output logic                    o_last,
`endif
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic [ID_W-1:0]         o_grant_id,
    input  logic                    i_ready
);

    out_state_t          state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic                load;
    logic                shake;
    logic [N_REQ-1:0]    eligible;
    logic [DATA_W-1:0]   sel_data;

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    logic                locked;
    logic [ID_W-1:0]     lock_id;
    logic                sel_last;
`endif

    assign o_valid = (state == FULL);

    // The stage can take a beat when empty or when its beat leaves this cycle.
    assign load = ~o_valid | i_ready;

    always_comb begin
        eligible = i_req_valid;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
        // Mid-packet only the owner may continue, even if it is idle.
        for (int k = 0; k < N_REQ; k++) begin
            eligible[k] = i_req_valid[k] & (~locked | (ID_W'(k) == lock_id));
        end
`endif
    end

    rr_pick #(
        .N   (N_REQ),
        .IDW (ID_W)
    ) u_pick (
        .req    (eligible),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        o_req_ready = '0;
        sel_data    = '0;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
        sel_last    = 1'b0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == winner) begin
                o_req_ready[k] = rst_n & load & found & i_req_valid[k];
                sel_data       = i_req_data[k*DATA_W +: DATA_W];
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
                sel_last       = i_req_last[k];
`endif
            end
        end
    end

    assign shake = |o_req_ready;

    always_comb begin
        state_nxt = state;
        if (shake) begin
            state_nxt = FULL;
        end else if (load) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data     <= '0;
            o_grant_id <= '0;
            ptr        <= '0;
        end else if (shake) begin
            o_data     <= sel_data;
            o_grant_id <= winner;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
            // Rotation happens between packets, not between beats.
            if (sel_last) begin
                ptr <= ID_W'(rr_next(32'(winner), N_REQ));
            end
`else
            ptr        <= ID_W'(rr_next(32'(winner), N_REQ));
`endif
        end
    end

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_last  <= 1'b0;
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (shake) begin
            o_last  <= sel_last;
            locked  <= ~sel_last;
            lock_id <= winner;
        end
    end
`endif

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
Round-robin arbiter sharing one valid/ready slave channel between N_REQ master interfaces.
Each requester presents valid/data and receives ready. The arbiter has a registered output stage: one beat is held toward the slave until it is accepted.
Sits between the bank of master interfaces and the single downstream slave port.

Parameters:
N_REQ, 4, number of requesters; 2..16; non-power-of-2 allowed
DATA_W, 32, beat width
ID_W, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  N_REQ  per-requester valid
i_req_data  in  N_REQ*DATA_W  requester k occupies bits [k*DATA_W +: DATA_W]
o_req_ready  out  N_REQ  per-requester ready; at most one bit high
o_valid  out  1  output beat valid (registered)
o_data  out  DATA_W  output beat (registered)
o_grant_id  out  ID_W  index of the requester that sourced o_data (registered)
i_ready  in  1  slave ready

Behaviour:
- Reset, asynchronous:
  - o_valid=0, o_data=0, o_grant_id=0, rr pointer ptr=0.
  - o_req_ready is forced to 0 while rst_n is low.
  - Assertion mid-operation drops any held beat immediately; no recovery.
- Output stage states:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1.
- load = ~o_valid | i_ready. This is a combinational path from i_ready to o_req_ready and is intended.
- Winner selection: first k with i_req_valid[k]=1, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
- o_req_ready[k] = rst_n & load & (k==winner) & i_req_valid[k]. Ready is one-hot or all zero.
- Input shake on requester k: i_req_valid[k] & o_req_ready[k]. Next edge:
  - o_valid<=1, o_data<=data[k], o_grant_id<=k
  - ptr<=(k==N_REQ-1)?0:k+1
- load=1 with no requester valid: o_valid<=0, and o_data/o_grant_id hold. Transitions: FULL→EMPTY, or stay EMPTY.
- load=0 (FULL and i_ready=0): all outputs hold and all o_req_ready=0.
- Latency and throughput:
  - Requester shake → o_valid at the next edge: 1 cycle.
  - With i_ready held high, one beat per cycle.
  - Simultaneous output drain and new load in the same cycle is required, with no bubble.
- Requester rules (checked by the bench, not the RTL):
  - valid, once high, stays high until its shake.
  - data is stable while valid is high and unaccepted.
- ptr changes only on a shake.

Optional Feature:
- Macro: RR_STREAM_ARBITER_PKT_LOCK_EN.
- Adds ports:
  - i_req_last  in  N_REQ  per-requester last-beat flag.
  - o_last  out  1  registered with o_data; reset value 0.
- Lock behaviour:
  - A shake with last=0 sets lock and records lock_id.
  - While locked, only lock_id is eligible; other requesters see ready=0 even if lock_id is idle.
  - A shake with last=1 clears lock.
  - ptr advances only on last-beat shakes.
  - Lock is cleared by reset.
- Without the macro: per-beat arbitration, no i_req_last/o_last ports, no lock state.

Decomposition:
- Package arb_pkg:
  - ARB_N_REQ_MAX=16
  - out_state_t enum {EMPTY, FULL}
  - function rr_next(idx, n) for wrap-around increment
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: request vector and ptr.
  - Outputs: winner index and found flag.
  - Reused by other arbiters in the codebase.

Test Plan:
- Reset:
  - Stimulus: all 4 valid and rst_n=0.
  - Response: o_req_ready=0000, o_valid=0.
  - First cycle after release: o_req_ready=0001, then o_grant_id=0 next cycle.
- Continuous traffic:
  - Stimulus: all 4 valid with data 0xA0..0xA3, i_ready=1.
  - Response: o_grant_id sequence 0,1,2,3,0,1…; o_valid high every cycle; o_data matches the source.
- Backpressure:
  - Stimulus: FULL with id 1, i_ready=0 for 5 cycles.
  - Response: o_data and o_grant_id stable, o_req_ready=0000.
  - After i_ready returns high: next grant is 2.
- Wrap and sparse traffic:
  - Stimulus: only req 2 valid for 3 beats (ptr=3), then req 1 joins.
  - Response: order 2,2,2,1,2,1; N_REQ=3 build wraps ptr 2→0.
- Packet lock (macro on):
  - Stimulus: req0 sends 3 beats with last on beat 3, req1 valid throughout.
  - Response: ids 0,0,0,1. With macro off, the same stimulus gives 0,1,0,1.
- Mid-operation reset:
  - Stimulus: rst_n dropped asynchronously while o_valid=1.
  - Response: o_valid=0 without waiting for a clock edge; ptr=0 after release.
